// File: rtl/modulator_pkg.sv
// Shared types and the chip-to-amplitude mapper for the DSSS modulator and its receiver relatives.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package modulator_pkg;

    typedef enum logic { MODE_BPSK = 1'b0, MODE_QPSK = 1'b1 } mode_t;
    typedef enum logic { IDLE = 1'b0, ACTIVE = 1'b1 } state_t;

    // Chip 0 -> +ampl, chip 1 -> -ampl, two's complement in the low 'width' bits.
    function automatic logic [63:0] chip_to_amp(input logic chip, input int ampl, input int width);
        logic [63:0] mag;
        logic [63:0] val;
        mag = 64'(ampl);
        val = chip ? (64'd0 - mag) : mag;
        if (width < 64) begin
            val = val & ((64'd1 << width) - 64'd1);
        end
        return val;
    endfunction

endpackage

// File: rtl/pn_lfsr.sv
// Fibonacci-style PN chip generator; o_chip is the current LSB of the register.
// Latency: load/step take effect on the next clock.
// Backpressure: none; advances only when the owner asserts i_step.
module pn_lfsr #(
    parameter int                   PN_DEGREE = 5,
    parameter logic [PN_DEGREE-1:0] PN_POLY   = 5'b00101,
    parameter logic [PN_DEGREE-1:0] PN_SEED   = 5'b11111
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_step,
    output logic o_chip
);

    logic [PN_DEGREE-1:0] lfsr_q;
    logic [PN_DEGREE-1:0] lfsr_d;

    // Reload the seed (priority) or shift right with the tapped parity entering at the top.
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_load) begin
            lfsr_d = PN_SEED;
        end else if (i_step) begin
            lfsr_d = {^(lfsr_q & PN_POLY), lfsr_q[PN_DEGREE-1:1]};
        end
    end

    // Register; reset returns to the seed so chip 0 of the first bit is well defined.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lfsr_q <= PN_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_chip = lfsr_q[0];

endmodule

// File: rtl/dsss_qpsk_modulator.sv
// Byte in, PN-spread BPSK/QPSK {Q,I} symbols out at one symbol per DIVIDER clocks.
// Latency: outputs register one clock after the rate strobe; a word waits for the next strobe.
// Backpressure: o_ready low while the single holding register is full; underrun pulse when starved.
module dsss_qpsk_modulator
    import modulator_pkg::*;
#(
    parameter int                   SIZE_INPUT_BIT  = 8,
    parameter int                   SIZE_OUTPUT_BIT = 32,
    parameter int                   SPREAD          = 24,
    parameter int                   DIVIDER         = 240,
    parameter int                   PN_DEGREE       = 5,
    parameter logic [PN_DEGREE-1:0] PN_POLY         = 5'b00101,
    parameter logic [PN_DEGREE-1:0] PN_SEED         = 5'b11111,
    parameter int                   AMPL            = 8192
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [SIZE_INPUT_BIT-1:0]    i_data,
    input  logic                         i_valid_input,
    input  logic                         i_mode,
    output logic                         o_ready,
    output logic [2*SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                         o_valid_output,
    output logic                         o_underrun
);

    localparam int DIV_W  = $clog2(DIVIDER);
    localparam int CHIP_W = $clog2(SPREAD + 1);
    localparam int BITS_W = $clog2(SIZE_INPUT_BIT + 1);
    localparam int OW     = SIZE_OUTPUT_BIT;

    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic                      strobe;
    logic                      hold_vld_q, hold_vld_d;
    logic [SIZE_INPUT_BIT-1:0] hold_dat_q, hold_dat_d;
    mode_t                     hold_mode_q, hold_mode_d;
    logic                      ready_q, ready_d;
    state_t                    state_q, state_d;
    logic [SIZE_INPUT_BIT-1:0] shift_q, shift_d;
    mode_t                     mode_q, mode_d;
    logic [BITS_W-1:0]         bits_q, bits_d;
    logic [CHIP_W-1:0]         chip_q, chip_d;
    logic                      started_q, started_d;
    logic [2*OW-1:0]           data_q, data_d;
    logic                      vld_q, vld_d;
    logic                      und_q, und_d;

    logic                      idle_load, run, reload, word_done, take;
    logic                      lfsr_load, lfsr_step, pn;
    logic [SIZE_INPUT_BIT-1:0] src_shift;
    mode_t                     src_mode;
    logic [BITS_W-1:0]         src_bits;
    logic [CHIP_W-1:0]         src_chip;
    logic                      chip_i, chip_qd;
    logic [OW-1:0]             i_amp, q_amp;

    pn_lfsr #(
        .PN_DEGREE (PN_DEGREE),
        .PN_POLY   (PN_POLY),
        .PN_SEED   (PN_SEED)
    ) u_pn (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (lfsr_load),
        .i_step  (lfsr_step),
        .o_chip  (pn)
    );

    // Free-running symbol-rate divider.
    always_comb begin
        strobe    = (div_cnt_q == DIV_W'(DIVIDER - 1));
        div_cnt_d = strobe ? '0 : div_cnt_q + DIV_W'(1);
    end

    // Chip/bit sequencing: an IDLE load emits chip 0 of the held word on the same strobe.
    always_comb begin
        idle_load = strobe && (state_q == IDLE) && hold_vld_q;
        run       = strobe && ((state_q == ACTIVE) || idle_load);
        src_shift = idle_load ? hold_dat_q : shift_q;
        src_mode  = idle_load ? hold_mode_q : mode_q;
        src_bits  = idle_load ? BITS_W'(SIZE_INPUT_BIT) : bits_q;
        src_chip  = idle_load ? '0 : chip_q;
        shift_d   = shift_q;
        mode_d    = mode_q;
        bits_d    = bits_q;
        chip_d    = chip_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        word_done = 1'b0;
        reload    = 1'b0;
        if (run) begin
            shift_d = src_shift;
            mode_d  = src_mode;
            bits_d  = src_bits;
            if (src_chip == CHIP_W'(SPREAD - 1)) begin
                chip_d    = '0;
                lfsr_load = 1'b1;
                if (src_mode == MODE_QPSK) begin
                    shift_d = src_shift << 2;
                    bits_d  = src_bits - BITS_W'(2);
                end else begin
                    shift_d = src_shift << 1;
                    bits_d  = src_bits - BITS_W'(1);
                end
                word_done = (bits_d == '0);
                // A word consumed by this very strobe cannot also be the follow-on word.
                reload    = word_done && hold_vld_q && !idle_load;
                if (reload) begin
                    shift_d = hold_dat_q;
                    mode_d  = hold_mode_q;
                    bits_d  = BITS_W'(SIZE_INPUT_BIT);
                end
            end else begin
                chip_d    = src_chip + CHIP_W'(1);
                lfsr_step = 1'b1;
            end
        end
        take = idle_load || reload;
    end

    // Holding register and its registered ready.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_dat_d  = hold_dat_q;
        hold_mode_d = hold_mode_q;
        if (ready_q && i_valid_input) begin
            hold_vld_d  = 1'b1;
            hold_dat_d  = i_data;
            hold_mode_d = mode_t'(i_mode);
        end else if (take) begin
            hold_vld_d  = 1'b0;
        end
        ready_d = ~hold_vld_d;
    end

    // Next state: a word finishing with nothing to chain returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (run) begin
            state_d = (word_done && !reload) ? IDLE : ACTIVE;
        end
    end

    // Output mapping: first bit of a pair on I, second on Q; zero symbol on a starved slot.
    always_comb begin
        chip_i    = src_shift[SIZE_INPUT_BIT-1] ^ pn;
        chip_qd   = src_shift[SIZE_INPUT_BIT-2] ^ pn;
        i_amp     = OW'(chip_to_amp(chip_i, AMPL, OW));
        q_amp     = (src_mode == MODE_QPSK) ? OW'(chip_to_amp(chip_qd, AMPL, OW)) : '0;
        data_d    = data_q;
        vld_d     = 1'b0;
        und_d     = 1'b0;
        started_d = started_q | idle_load;
        if (run) begin
            data_d = {q_amp, i_amp};
            vld_d  = 1'b1;
        end else if (strobe && (state_q == IDLE) && started_q) begin
            data_d = '0;
            vld_d  = 1'b1;
            und_d  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset drops everything in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_cnt_q   <= '0;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= '0;
            hold_mode_q <= MODE_BPSK;
            ready_q     <= 1'b0;
            shift_q     <= '0;
            mode_q      <= MODE_BPSK;
            bits_q      <= '0;
            chip_q      <= '0;
            started_q   <= 1'b0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            hold_vld_q  <= hold_vld_d;
            hold_dat_q  <= hold_dat_d;
            hold_mode_q <= hold_mode_d;
            ready_q     <= ready_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            bits_q      <= bits_d;
            chip_q      <= chip_d;
            started_q   <= started_d;
            data_q      <= data_d;
            vld_q       <= vld_d;
            und_q       <= und_d;
        end
    end

    assign o_ready        = ready_q;
    assign o_data         = data_q;
    assign o_valid_output = vld_q;
    assign o_underrun     = und_q;

endmodule
